// File: rtl/vram_text_scanout_if.sv
// vram_text_scanout_if: VRAM port B / font ROM read bus, cursor and start controls, and video outputs.
interface vram_text_scanout_if;
    logic [11:0] start_addr;
    logic        cursor_en;
    logic [11:0] cursor_addr;
    logic [11:0] vram_adb;
    logic        vram_ceb;
    logic [7:0]  vram_dout;
    logic [11:0] font_ad;
    logic        font_ce;
    logic [7:0]  font_dout;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        pix;
    logic        frame_start;
    modport master (
        input  start_addr, cursor_en, cursor_addr, vram_dout, font_dout,
        output vram_adb, vram_ceb, font_ad, font_ce, hsync, vsync, de, pix, frame_start
    );
    modport slave (
        output start_addr, cursor_en, cursor_addr, vram_dout, font_dout,
        input  vram_adb, vram_ceb, font_ad, font_ce, hsync, vsync, de, pix, frame_start
    );
endinterface

// File: rtl/vram_text_scanout.sv
// vram_text_scanout: raster timing, character/font fetch and 1-bit pixel serialiser with blinking cursor.
module vram_text_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int COLS     = 80,
    parameter bit SYNC_POL = 1'b0
) (
    input logic clk,
    input logic reset,
    vram_text_scanout_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [11:0]   row_base_q, row_base_d;
    logic [4:0]    frame_cnt_q, frame_cnt_d;
    logic [7:0]    sr_q, sr_d;
    logic          cur_q, cur_d;
    logic [2:0]    de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic          h_end, v_end, vis, ph0, ph1, ph2, cur_hit, ceb, fce;
    logic [11:0]   cell_addr;
    always_comb begin
        h_end       = hcnt_q == HW'(H_TOTAL - 1);
        v_end       = vcnt_q == VW'(V_TOTAL - 1);
        vis         = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
        ph0         = vis && hcnt_q[2:0] == 3'd0;
        ph1         = vis && hcnt_q[2:0] == 3'd1;
        ph2         = vis && hcnt_q[2:0] == 3'd2;
        cell_addr   = row_base_q + 12'(hcnt_q >> 3);
        cur_hit     = bus.cursor_en && cell_addr == bus.cursor_addr && vcnt_q[3:1] == 3'b111 && frame_cnt_q[4];
        hcnt_d      = h_end ? '0 : hcnt_q + HW'(1);
        vcnt_d      = !h_end ? vcnt_q : v_end ? '0 : vcnt_q + VW'(1);
        row_base_d  = !h_end ? row_base_q :
                      v_end ? bus.start_addr :
                      (vcnt_q < VW'(V_ACTIVE) && vcnt_q[3:0] == 4'hF) ? row_base_q + 12'(COLS) : row_base_q;
        frame_cnt_d = frame_cnt_q + 5'(h_end && v_end);
        cur_d       = ph1 ? cur_hit : cur_q;
        // cell address and cursor match are resolved during phase 1, pixels enter at phase 2
        sr_d        = ph2 ? bus.font_dout ^ {8{cur_q}} : {sr_q[6:0], 1'b0};
        de_d        = {de_q[1:0], vis};
        hs_d        = {hs_q[1:0], hcnt_q >= HW'(H_ACTIVE + H_FP) && hcnt_q < HW'(H_ACTIVE + H_FP + H_SYNC)};
        vs_d        = {vs_q[1:0], vcnt_q >= VW'(V_ACTIVE + V_FP) && vcnt_q < VW'(V_ACTIVE + V_FP + V_SYNC)};
        fs_d        = {fs_q[1:0], hcnt_q == '0 && vcnt_q == '0};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            row_base_q  <= '0;
            frame_cnt_q <= '0;
            sr_q        <= '0;
            cur_q       <= 1'b0;
            de_q        <= '0;
            hs_q        <= '0;
            vs_q        <= '0;
            fs_q        <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            row_base_q  <= row_base_d;
            frame_cnt_q <= frame_cnt_d;
            sr_q        <= sr_d;
            cur_q       <= cur_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            fs_q        <= fs_d;
        end
    end
    // strobes are combinational so the memories see them in the phase cycle itself; reset masks them
    assign ceb             = !reset && ph0;
    assign fce             = !reset && ph1;
    assign bus.vram_ceb    = ceb;
    assign bus.vram_adb    = ceb ? cell_addr : '0;
    assign bus.font_ce     = fce;
    assign bus.font_ad     = fce ? {bus.vram_dout, vcnt_q[3:0]} : '0;
    assign bus.de          = de_q[2];
    assign bus.pix         = de_q[2] & sr_q[7];
    assign bus.hsync       = hs_q[2] ~^ SYNC_POL;
    assign bus.vsync       = vs_q[2] ~^ SYNC_POL;
    assign bus.frame_start = fs_q[2];
endmodule
